pic_host: RTL and testbench

CPU-side bus master for the `pic` interrupt controller. It converts single-register host commands into `pic` bus cycles on the shared tri-state `data` bus, using `select`, `readwrite` and `intack`. When `int` is raised it runs the acknowledge sequence on its own: pulse `intack`, read the vector from `SEL_OCR`, write an end-of-interrupt command, then report the vector upstream. It sits between the processor model and `pic` in the system top.

---
 rtl/pic_host.sv | 103 ++++++++++
 tb/tb_pic_host.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pic_host.sv
// pic_host: CPU-side bus master for the pic interrupt controller.
// Turns single-register host commands into pic bus cycles and runs the
// interrupt acknowledge sequence (intack, vector read, EOI) on its own.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_write/cmd_sel/cmd_wdata : host command channel
//   rsp_valid/rsp_rdata                             : command completion
//   irq_valid/irq_vector                            : interrupt service completion
//   busy                                            : not idle
//   data (inout), select, readwrite, intack         : pic bus
//   intr                                            : pic interrupt request (int is a keyword)
module pic_host #(
  parameter logic [7:0] EOI_CMD = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       irq_valid,
  output logic [7:0] irq_vector,
  output logic       busy,
  inout  wire  [7:0] data,
  output logic [1:0] select,
  output logic       readwrite,
  output logic       intack,
  input  logic       intr
);
  localparam logic [1:0] SEL_OCR  = 2'd0;
  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;

  typedef enum logic [3:0] {
    IDLE, WR, RD_ADDR, RD_SAMP, RSP, ACK, VRD_ADDR, VRD_SAMP, EOI, DONE
  } state_t;

  state_t     r_state, w_next;
  logic       r_write;
  logic [1:0] r_sel;
  logic [7:0] r_wdata, r_rdata, r_vec;
  logic       w_accept, w_oe, w_cmd_bus;

  // reset gates cmd_ready so nothing is offered while held in reset
  assign cmd_ready  = reset && r_state == IDLE && !intr;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_oe       = r_state == WR || r_state == EOI;
  assign w_cmd_bus  = r_state == WR || r_state == RD_ADDR || r_state == RD_SAMP;
  assign busy       = r_state != IDLE;
  assign rsp_valid  = r_state == RSP;
  assign irq_valid  = r_state == DONE;
  assign intack     = r_state == ACK;
  assign rsp_rdata  = r_rdata;
  assign irq_vector = r_vec;
  assign select     = w_cmd_bus ? r_sel : SEL_OCR;
  assign readwrite  = w_oe ? RW_WRITE : RW_READ;
  assign data       = w_oe ? (r_state == EOI ? EOI_CMD : r_wdata) : 8'hzz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_sel   <= SEL_OCR;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_vec   <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= cmd_write;
        r_sel   <= cmd_sel;
        r_wdata <= cmd_wdata;
        r_rdata <= 8'h00;
      end
      if (r_state == RD_SAMP) r_rdata <= data;
      if (r_state == VRD_SAMP) r_vec <= data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = intr ? ACK : w_accept ? (cmd_write ? WR : RD_ADDR) : IDLE;
      WR:       w_next = RSP;
      RD_ADDR:  w_next = RD_SAMP;
      RD_SAMP:  w_next = RSP;
      RSP:      w_next = IDLE;
      ACK:      w_next = VRD_ADDR;
      VRD_ADDR: w_next = VRD_SAMP;
      VRD_SAMP: w_next = EOI;
      EOI:      w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // r_write only records the accepted direction; the state already encodes it
  logic w_unused;
  assign w_unused = r_write;
endmodule

// File: tb/tb_pic_host.sv
// tb_pic_host: directed plus randomized checks of pic_host against a pic bus model.
module tb_pic_host;
  localparam logic [1:0] SEL_OCR  = 2'd0;
  localparam logic [1:0] SEL_IMR  = 2'd3;
  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;
  localparam logic [7:0] EOI_CMD  = 8'h20;

  logic       clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0, intr = 1'b0;
  logic [1:0] cmd_sel = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, irq_valid, busy, readwrite, intack;
  logic [7:0] rsp_rdata, irq_vector;
  logic [1:0] select;
  wire  [7:0] data;

  // pic model: register file written over the bus, OCR returns the pending vector
  logic [7:0] pic_regs [4] = '{default: 8'h00};
  logic [7:0] ocr_val = 8'h5a;
  logic [7:0] last_ocr_wr = 8'h00;
  int         ocr_wr_cnt = 0;
  // reference: what each register should hold after the commands issued so far
  logic [7:0] ref_regs [4] = '{default: 8'h00};
  int         n_cmp = 0, n_bad = 0;

  pic_host #(.EOI_CMD(EOI_CMD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq_valid(irq_valid),
    .irq_vector(irq_vector), .busy(busy), .data(data), .select(select),
    .readwrite(readwrite), .intack(intack), .intr(intr)
  );

  // the model drives whenever the host is in read mode, so a released bus
  // shows the model's value and any host drive corrupts it
  assign data = (readwrite == RW_READ) ? (select == SEL_OCR ? ocr_val : pic_regs[select]) : 8'hzz;

  always @(posedge clk) begin
    if (reset && readwrite == RW_WRITE) begin
      if (select == SEL_OCR) begin
        last_ocr_wr <= data;
        ocr_wr_cnt  <= ocr_wr_cnt + 1;
      end else pic_regs[select] <= data;
    end
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] sel, input logic rw, input logic [7:0] d);
    chk({tag, ".select"}, {6'd0, select}, {6'd0, sel});
    chk({tag, ".readwrite"}, {7'd0, readwrite}, {7'd0, rw});
    chk({tag, ".data"}, data, d);
  endtask

  task automatic do_cmd(input logic wr, input logic [1:0] sel, input logic [7:0] wd);
    int t = 0;
    while (!cmd_ready && t < 20) begin step(); t++; end
    chk("cmd_ready_wait", {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sel; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_sel = 2'($urandom); cmd_wdata = 8'($urandom);
    if (wr) begin
      chk_bus("wr_cycle", sel, RW_WRITE, wd);
      ref_regs[sel] = wd;
      step();
      chk("wr_rsp_valid", {7'd0, rsp_valid}, 8'd1);
      chk("wr_rsp_rdata", rsp_rdata, 8'h00);
      chk_bus("wr_released", SEL_OCR, RW_READ, ocr_val);
    end else begin
      chk_bus("rd_addr", sel, RW_READ, ref_regs[sel]);
      chk("rd_addr_rsp", {7'd0, rsp_valid}, 8'd0);
      step();
      chk_bus("rd_samp", sel, RW_READ, ref_regs[sel]);
      step();
      chk("rd_rsp_valid", {7'd0, rsp_valid}, 8'd1);
      chk("rd_rsp_rdata", rsp_rdata, ref_regs[sel]);
    end
    step();
    chk("cmd_end_rsp", {7'd0, rsp_valid}, 8'd0);
    chk("cmd_end_busy", {7'd0, busy}, 8'd0);
  endtask

  // assumes IDLE with int low at entry; leaves the bench in the IDLE cycle after DONE
  task automatic service(input logic [7:0] vec);
    int n0 = ocr_wr_cnt;
    ocr_val = vec;
    intr = 1'b1;
    step();
    chk("ack_intack", {7'd0, intack}, 8'd1);
    chk("ack_busy", {7'd0, busy}, 8'd1);
    chk("ack_ready", {7'd0, cmd_ready}, 8'd0);
    intr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("vrd_intack", {7'd0, intack}, 8'd0);
      chk("vrd_ready", {7'd0, cmd_ready}, 8'd0);
      chk_bus("vrd", SEL_OCR, RW_READ, vec);
    end
    step();
    chk_bus("eoi", SEL_OCR, RW_WRITE, EOI_CMD);
    chk("eoi_irq_valid", {7'd0, irq_valid}, 8'd0);
    step();
    chk("done_irq_valid", {7'd0, irq_valid}, 8'd1);
    chk("done_vector", irq_vector, vec);
    chk("done_busy", {7'd0, busy}, 8'd1);
    chk("eoi_count", 8'(ocr_wr_cnt - n0), 8'd1);
    chk("eoi_value", last_ocr_wr, EOI_CMD);
    step();
    chk("post_irq_valid", {7'd0, irq_valid}, 8'd0);
    chk("post_busy", {7'd0, busy}, 8'd0);
    chk("post_vector", irq_vector, vec);
  endtask

  initial begin
    // reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      chk_bus("reset", SEL_OCR, RW_READ, ocr_val);
      chk("reset_ready", {7'd0, cmd_ready}, 8'd0);
      chk("reset_busy", {7'd0, busy}, 8'd0);
      chk("reset_rdata", rsp_rdata, 8'h00);
      chk("reset_vector", irq_vector, 8'h00);
    end
    reset = 1'b1;
    step();
    chk("release_ready", {7'd0, cmd_ready}, 8'd1);

    do_cmd(1'b1, SEL_IMR, 8'h22);
    do_cmd(1'b0, SEL_IMR, 8'h00);

    // abort in VRD_SAMP
    ocr_val = 8'h41;
    intr = 1'b1;
    step();
    intr = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_intack", {7'd0, intack}, 8'd0);
    chk_bus("abort_bus", SEL_OCR, RW_READ, 8'h41);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abort_irq_valid", {7'd0, irq_valid}, 8'd0);
      chk("abort_vector", irq_vector, 8'h00);
    end
    reset = 1'b1;
    step();
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_vector_after", irq_vector, 8'h00);

    service(8'h41);

    // int and a command rise together: service first, command after DONE
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = SEL_IMR; cmd_wdata = 8'h5c;
    service(8'h93);
    chk("prio_ready", {7'd0, cmd_ready}, 8'd1);
    step();
    cmd_valid = 1'b0;
    chk_bus("prio_wr", SEL_IMR, RW_WRITE, 8'h5c);
    ref_regs[SEL_IMR] = 8'h5c;
    step();
    chk("prio_rsp", {7'd0, rsp_valid}, 8'd1);
    step();

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) service(8'($urandom));
      else do_cmd(1'($urandom), 2'($urandom_range(1, 3)), 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    for (int s = 1; s < 4; s++) do_cmd(1'b0, 2'(s), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
